// File: rtl/alu_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_collector
// Description : Captures ALU results into a FIFO, each tagged with the irq
//               level, and runs the interrupt-clear handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_collector #(
  parameter int DEPTH       = 8,
  parameter int RES_LAT     = 1,
  parameter int CLR_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_enable,
  input  logic [7:0]               alu_out,
  input  logic                     alu_irq,
  output logic                     alu_irq_clr,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [7:0]               rd_data,
  output logic                     rd_irq_tag,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_count,
  output logic [7:0]               irq_count,
  output logic                     irq_stuck,
  input  logic                     clear_flags
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam int c_TW = $clog2(CLR_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    WAIT = 2'd2
  } irq_state_t;

  logic [RES_LAT-1:0] r_en_dly;
  logic [8:0]         r_mem [DEPTH];
  logic [c_AW-1:0]    r_wr_ptr;
  logic [c_AW-1:0]    r_rd_ptr;
  logic [c_LW-1:0]    r_count;
  logic               r_overflow;
  logic [7:0]         r_drop_count;
  logic [7:0]         r_irq_count;
  logic               r_irq_stuck;
  logic               r_irq_prev;
  irq_state_t         r_state;
  irq_state_t         w_state_nxt;
  logic [c_TW-1:0]    r_timer;
  logic [c_TW-1:0]    w_timer_nxt;
  logic               w_push, w_pop, w_full, w_wr, w_drop;
  logic               w_clr, w_edge_cnt, w_stuck_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_dly <= '0;
    end else begin
      r_en_dly[0] <= alu_enable;
      for (int i = 1; i < RES_LAT; i++) r_en_dly[i] <= r_en_dly[i-1];
    end
  end

  assign w_push = r_en_dly[RES_LAT-1];
  assign w_full = (r_count == c_LW'(DEPTH));
  assign w_pop  = rd_valid & rd_ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign w_wr   = w_push & (~w_full | w_pop);
  assign w_drop = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {alu_irq, alu_out};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + c_LW'(1);
        2'b01:   r_count <= r_count - c_LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_valid                = (r_count != '0);
  assign {rd_irq_tag, rd_data}   = rd_valid ? r_mem[r_rd_ptr] : 9'd0;
  assign level                   = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_irq_prev <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_irq_prev <= alu_irq;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_clr       = 1'b0;
    w_edge_cnt  = 1'b0;
    w_stuck_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (alu_irq && !r_irq_prev) begin
          w_edge_cnt  = 1'b1;
          w_state_nxt = CLR;
        end
      end
      CLR: begin
        w_clr       = 1'b1;
        w_state_nxt = WAIT;
        w_timer_nxt = c_TW'(CLR_TIMEOUT);
      end
      WAIT: begin
        if (!alu_irq) begin
          w_state_nxt = IDLE;
        end else if (r_timer <= c_TW'(1)) begin
          w_stuck_set = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_timer_nxt = r_timer - c_TW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign alu_irq_clr = w_clr;

  // clear_flags takes priority, so a coinciding drop or edge is lost.
  always_ff @(posedge clk) begin
    if (rst || clear_flags) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
      r_irq_count  <= '0;
      r_irq_stuck  <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
      end
      if (w_edge_cnt && r_irq_count != 8'hFF) r_irq_count <= r_irq_count + 8'd1;
      if (w_stuck_set) r_irq_stuck <= 1'b1;
    end
  end

  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign irq_count  = r_irq_count;
  assign irq_stuck  = r_irq_stuck;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_collector
// Description : Scoreboard bench for alu_result_collector (FIFO path and irq
//               clear handshake).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_collector;

  localparam int c_DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst, alu_enable, alu_irq, rd_ready, clear_flags;
  logic [7:0] alu_out;
  logic       alu_irq_clr, rd_valid, rd_irq_tag, overflow, irq_stuck;
  logic [7:0] rd_data, drop_count, irq_count;
  logic [3:0] level;

  alu_result_collector #(.DEPTH(c_DEPTH), .RES_LAT(1), .CLR_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .alu_enable(alu_enable), .alu_out(alu_out),
    .alu_irq(alu_irq), .alu_irq_clr(alu_irq_clr), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_irq_tag(rd_irq_tag),
    .level(level), .overflow(overflow), .drop_count(drop_count),
    .irq_count(irq_count), .irq_stuck(irq_stuck), .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [8:0] q[$];
  logic       m_dly;
  logic       m_ovf;
  int         m_drops;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Check occupancy/flags, score the head on a pop, update the model, then clock.
  task automatic cycle();
    logic push, pop;
    chk("level", 32'(level), 32'(q.size()));
    chk("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drops));
    push = m_dly;
    pop  = rd_ready && (q.size() != 0);
    if (pop) begin
      chk("rd_head", 32'({rd_irq_tag, rd_data}), 32'(q[0]));
      void'(q.pop_front());
    end
    if (push) begin
      if (q.size() < c_DEPTH) q.push_back({alu_irq, alu_out});
      else begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
    if (clear_flags) begin
      m_ovf   = 1'b0;
      m_drops = 0;
    end
    m_dly = alu_enable;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; alu_enable = 1'b0; alu_out = 8'h00; alu_irq = 1'b0;
    rd_ready = 1'b0; clear_flags = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_dly = 1'b0; m_ovf = 1'b0; m_drops = 0;
  endtask

  initial begin
    do_reset();
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_clr", 32'(alu_irq_clr), 0);
    chk("rst_flags", 32'({overflow, irq_stuck, drop_count, irq_count}), 0);
    chk("rst_data", 32'({rd_irq_tag, rd_data}), 0);

    // Single result through the FIFO
    alu_enable = 1'b1; cycle();
    alu_enable = 1'b0; alu_out = 8'h3C; cycle();
    chk("t1_valid", 32'(rd_valid), 1);
    chk("t1_data", 32'(rd_data), 32'h3C);
    chk("t1_tag", 32'(rd_irq_tag), 0);
    rd_ready = 1'b1; cycle();
    rd_ready = 1'b0; cycle();
    chk("t1_empty", 32'(rd_valid), 0);

    // Fill with 0x01..0x08, 0x09 is dropped
    for (int i = 0; i < 10; i++) begin
      alu_enable = (i < 9);
      alu_out    = 8'(i);
      cycle();
    end
    alu_enable = 1'b0;
    chk("t2_level", 32'(level), 8);
    chk("t2_ovf", 32'(overflow), 1);
    chk("t2_drops", 32'(drop_count), 1);

    // Push 0x0A while full with a simultaneous pop: no drop
    alu_enable = 1'b1; cycle();
    alu_enable = 1'b0; alu_out = 8'h0A; rd_ready = 1'b1; cycle();
    rd_ready = 1'b0;
    chk("t3_level", 32'(level), 8);
    chk("t3_drops", 32'(drop_count), 1);
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    rd_ready = 1'b0; cycle();
    chk("t3_drained", 32'(q.size()), 0);

    // irq rises, drops two cycles after the clear pulse
    alu_irq = 1'b1; cycle();
    chk("t4_clr_pulse", 32'(alu_irq_clr), 1);
    chk("t4_irq_count", 32'(irq_count), 1);
    cycle();
    chk("t4_clr_low", 32'(alu_irq_clr), 0);
    cycle();
    alu_irq = 1'b0; cycle();
    cycle();
    chk("t4_clr_idle", 32'(alu_irq_clr), 0);
    chk("t4_stuck", 32'(irq_stuck), 0);
    alu_irq = 1'b1; cycle();
    chk("t4_retrig_clr", 32'(alu_irq_clr), 1);
    chk("t4_retrig_cnt", 32'(irq_count), 2);
    alu_irq = 1'b0; cycle();
    clear_flags = 1'b1; cycle();
    clear_flags = 1'b0;
    chk("t4_cleared", 32'(irq_count), 0);

    // irq held high for 10 cycles
    alu_irq = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      cycle();
      chk("t5_clr", 32'(alu_irq_clr), 32'(j == 1));
      chk("t5_stuck", 32'(irq_stuck), 32'(j >= 6));
    end
    chk("t5_count", 32'(irq_count), 1);
    alu_irq = 1'b0; clear_flags = 1'b1; cycle();
    clear_flags = 1'b0;
    chk("t5_clr_stuck", 32'(irq_stuck), 0);
    chk("t5_clr_count", 32'(irq_count), 0);

    // Reset mid-WAIT with 3 entries buffered
    for (int i = 0; i < 4; i++) begin
      alu_enable = (i < 3);
      alu_out    = 8'(8'h50 + i);
      cycle();
    end
    alu_enable = 1'b0;
    alu_irq = 1'b1; cycle();
    cycle();
    chk("t6_pre_level", 32'(level), 3);
    do_reset();
    chk("t6_level", 32'(level), 0);
    chk("t6_valid", 32'(rd_valid), 0);
    chk("t6_clr", 32'(alu_irq_clr), 0);
    chk("t6_flags", 32'({overflow, irq_stuck, drop_count, irq_count}), 0);

    // irq held high through reset counts as an edge afterwards
    rst = 1'b1; alu_irq = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t7_cnt0", 32'(irq_count), 0);
    @(posedge clk); #1;
    chk("t7_clr", 32'(alu_irq_clr), 1);
    chk("t7_cnt1", 32'(irq_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
